// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings,
// default handshake timeout and the bundled decoder control lines.
package ctrl_pkg;

  // Default number of cycles a memory request may wait for its ack.
  localparam int ACK_TIMEOUT_DEF = 16;

  // Width of the shared handshake wait counter.
  localparam int WAIT_W = 8;

  // Sequencer states; encodings are visible on the state output.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALTED = 3'd6,
    ST_ERR    = 3'd7
  } seq_state_e;

  // Control lines produced by the combinational instruction decoder.
  typedef struct packed {
    logic halt;
    logic reg_write;
    logic mem_write;
    logic sel_wb;
    logic jump;
    logic branch;
  } dec_bus_t;

  // Next-PC select: take the target on a jump or a taken branch.
  function automatic logic wb_pc_sel(input dec_bus_t d, input logic taken);
    return d.jump | (d.branch & taken);
  endfunction

  // Instructions that need a data-memory access before writeback.
  function automatic logic needs_mem(input dec_bus_t d);
    return d.mem_write | d.sel_wb;
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Wait counter shared by the FETCH and MEM handshakes. It is held at zero
// while clear is high, counts each enabled cycle, and flags expire once the
// count reaches LIMIT-1.
module ack_timer
  import ctrl_pkg::*;
#(
  parameter int LIMIT = ACK_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [WAIT_W-1:0] count;

  // Count unacknowledged cycles; saturate so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {WAIT_W{1'b0}};
    end else if (clear) begin
      count <= {WAIT_W{1'b0}};
    end else if (enable && (count != {WAIT_W{1'b1}})) begin
      count <= count + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign expire = (count == WAIT_W'(LIMIT - 1));

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit core. Steps each
// instruction through FETCH, DECODE, EXEC, optional MEM and WB, runs the
// instruction/data memory handshakes and stops on halt or ack timeout.
// Every output except ir_we is a flop loaded together with the next state.
module mc_sequencer
  import ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int RET_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             dec_halt,
  input  logic             dec_reg_write,
  input  logic             dec_mem_write,
  input  logic             dec_sel_wb,
  input  logic             dec_jump,
  input  logic             dec_branch,
  input  logic             br_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [RET_W-1:0] retired
);

  seq_state_e cur_state;
  dec_bus_t   dec;
  logic       timer_clear;
  logic       timer_en;
  logic       timer_expire;
  logic       in_fetch;
  logic       in_mem;

  assign dec = '{halt:      dec_halt,
                 reg_write: dec_reg_write,
                 mem_write: dec_mem_write,
                 sel_wb:    dec_sel_wb,
                 jump:      dec_jump,
                 branch:    dec_branch};

  assign in_fetch = (cur_state == ST_FETCH);
  assign in_mem   = (cur_state == ST_MEM);

  // The counter sits at zero outside the two wait states, so it starts from
  // zero on every entry to FETCH or MEM and only counts missing acks there.
  assign timer_clear = !(in_fetch || in_mem);
  assign timer_en    = (in_fetch && !imem_ack) || (in_mem && !dmem_ack);

  ack_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .expire (timer_expire)
  );

  // IR load must coincide with the fetch data, so it follows the ack directly.
  assign ir_we = in_fetch && imem_ack;
  assign state = cur_state;

  // Sequencer FSM: next state plus the registered strobes for that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_IDLE;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      pc_we     <= 1'b0;
      pc_sel    <= 1'b0;
      rf_we     <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
      retired   <= {RET_W{1'b0}};
    end else begin
      // Strobes are single-state; each transition below re-asserts its own.
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      pc_we    <= 1'b0;
      pc_sel   <= 1'b0;
      rf_we    <= 1'b0;
      halted   <= 1'b0;
      err      <= 1'b0;
      retired  <= retired;
      case (cur_state)
        ST_IDLE: begin
          if (start) begin
            cur_state <= ST_FETCH;
            imem_req  <= 1'b1;
          end else begin
            cur_state <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            cur_state <= ST_DECODE;
          end else if (timer_expire) begin
            cur_state <= ST_ERR;
            err       <= 1'b1;
          end else begin
            cur_state <= ST_FETCH;
            imem_req  <= 1'b1;
          end
        end
        ST_DECODE: begin
          cur_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dec.halt) begin
            cur_state <= ST_HALTED;
            halted    <= 1'b1;
          end else if (needs_mem(dec)) begin
            cur_state <= ST_MEM;
            dmem_req  <= 1'b1;
            dmem_we   <= dec.mem_write;
          end else begin
            cur_state <= ST_WB;
            pc_we     <= 1'b1;
            pc_sel    <= wb_pc_sel(dec, br_taken);
            rf_we     <= dec.reg_write;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            cur_state <= ST_WB;
            pc_we     <= 1'b1;
            pc_sel    <= wb_pc_sel(dec, br_taken);
            rf_we     <= dec.reg_write;
          end else if (timer_expire) begin
            cur_state <= ST_ERR;
            err       <= 1'b1;
          end else begin
            cur_state <= ST_MEM;
            dmem_req  <= 1'b1;
            dmem_we   <= dec.mem_write;
          end
        end
        ST_WB: begin
          cur_state <= ST_FETCH;
          imem_req  <= 1'b1;
          if (retired != {RET_W{1'b1}}) begin
            retired <= retired + RET_W'(1);
          end else begin
            retired <= retired;
          end
        end
        ST_HALTED: begin
          if (start) begin
            cur_state <= ST_FETCH;
            imem_req  <= 1'b1;
          end else begin
            cur_state <= ST_HALTED;
            halted    <= 1'b1;
          end
        end
        ST_ERR: begin
          cur_state <= ST_ERR;
          err       <= 1'b1;
        end
        default: begin
          cur_state <= ST_ERR;
          err       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer. Instruction stimulus pushes the
// expected writeback strobes onto a scoreboard queue; a monitor pops and
// compares them whenever the sequencer raises pc_we.
module tb_mc_sequencer;

  typedef struct {
    logic pc_sel;
    logic rf_we;
  } wb_exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        dec_halt;
  logic        dec_reg_write;
  logic        dec_mem_write;
  logic        dec_sel_wb;
  logic        dec_jump;
  logic        dec_branch;
  logic        br_taken;
  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic        rf_we;
  logic [2:0]  state;
  logic        halted;
  logic        err;
  logic [15:0] retired;

  int      n_checks = 0;
  int      n_fail   = 0;
  wb_exp_t sb[$];

  mc_sequencer #(
    .ACK_TIMEOUT (4),
    .RET_W       (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ack      (dmem_ack),
    .dec_halt      (dec_halt),
    .dec_reg_write (dec_reg_write),
    .dec_mem_write (dec_mem_write),
    .dec_sel_wb    (dec_sel_wb),
    .dec_jump      (dec_jump),
    .dec_branch    (dec_branch),
    .br_taken      (br_taken),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .pc_sel        (pc_sel),
    .rf_we         (rf_we),
    .state         (state),
    .halted        (halted),
    .err           (err),
    .retired       (retired)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every writeback strobe must match a queued entry.
  always @(negedge clk) begin
    if (rst_n && pc_we) begin
      if (sb.size() == 0) begin
        chk_eq("unexpected_pc_we", 32'(pc_we), 32'd0);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        chk_eq("wb_state", 32'(state), 32'd5);
        chk_eq("wb_pc_sel", 32'(pc_sel), 32'(e.pc_sel));
        chk_eq("wb_rf_we", 32'(rf_we), 32'(e.rf_we));
      end
    end
  end

  // Runs one non-halt instruction starting in FETCH (just after an edge).
  task automatic run_instr(input logic rw, input logic mw, input logic swb,
                           input logic jmp, input logic brn, input logic bt,
                           input int iw, input int dw, input logic [15:0] exp_ret);
    wb_exp_t e;
    dec_halt = 1'b0; dec_reg_write = rw; dec_mem_write = mw;
    dec_sel_wb = swb; dec_jump = jmp; dec_branch = brn; br_taken = bt;
    e.pc_sel = jmp | (brn & bt);
    e.rf_we  = rw;
    for (int i = 0; i < iw; i++) begin
      imem_ack = 1'b0;
      #1;
      chk_eq("fetch_wait_state", 32'(state), 32'd1);
      chk_eq("fetch_wait_req", 32'(imem_req), 32'd1);
      chk_eq("fetch_wait_ir_we", 32'(ir_we), 32'd0);
      step();
    end
    imem_ack = 1'b1;
    #1;
    chk_eq("fetch_state", 32'(state), 32'd1);
    chk_eq("fetch_req", 32'(imem_req), 32'd1);
    chk_eq("fetch_ir_we", 32'(ir_we), 32'd1);
    step();
    imem_ack = 1'b0;
    chk_eq("decode_state", 32'(state), 32'd2);
    chk_eq("decode_req", 32'(imem_req), 32'd0);
    step();
    chk_eq("exec_state", 32'(state), 32'd3);
    if (mw || swb) begin
      step();
      for (int i = 0; i < dw; i++) begin
        chk_eq("mem_wait_state", 32'(state), 32'd4);
        chk_eq("mem_wait_req", 32'(dmem_req), 32'd1);
        chk_eq("mem_wait_we", 32'(dmem_we), 32'(mw));
        step();
      end
      dmem_ack = 1'b1;
      #1;
      chk_eq("mem_state", 32'(state), 32'd4);
      chk_eq("mem_req", 32'(dmem_req), 32'd1);
      chk_eq("mem_we", 32'(dmem_we), 32'(mw));
      sb.push_back(e);
      step();
      dmem_ack = 1'b0;
    end else begin
      sb.push_back(e);
      step();
    end
    chk_eq("wb_state_seq", 32'(state), 32'd5);
    chk_eq("wb_dmem_req", 32'(dmem_req), 32'd0);
    step();
    chk_eq("next_fetch_state", 32'(state), 32'd1);
    chk_eq("retired", 32'(retired), 32'(exp_ret));
  endtask

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_halt = 1'b0; dec_reg_write = 1'b0; dec_mem_write = 1'b0;
    dec_sel_wb = 1'b0; dec_jump = 1'b0; dec_branch = 1'b0; br_taken = 1'b0;
    #12;
    chk_eq("rst_state", 32'(state), 32'd0);
    chk_eq("rst_strobes", {23'd0, imem_req, dmem_req, dmem_we, ir_we, pc_we,
                           pc_sel, rf_we, halted, err}, 32'd0);
    chk_eq("rst_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    step();
    chk_eq("idle_hold", 32'(state), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_eq("start_fetch", 32'(state), 32'd1);

    // rw mw swb jmp brn bt iwait dwait retired
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'd1); // ALU
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 16'd2); // store, ack late
    run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 16'd3); // load
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 16'd4); // taken branch
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 16'd5); // not taken
    run_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 16'd6); // jump
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 16'd7); // ack on 4th fetch cycle

    // Halt: EXEC with dec_halt goes to HALTED without a PC update.
    dec_halt = 1'b1; dec_reg_write = 1'b1; dec_jump = 1'b0; dec_branch = 1'b0;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    chk_eq("halt_exec", 32'(state), 32'd3);
    step();
    chk_eq("halt_state", 32'(state), 32'd6);
    chk_eq("halt_flag", 32'(halted), 32'd1);
    chk_eq("halt_pc_we", 32'(pc_we), 32'd0);
    step();
    chk_eq("halt_hold", 32'(state), 32'd6);
    chk_eq("halt_retired", 32'(retired), 32'd7);
    start = 1'b1;
    step();
    start = 1'b0;
    dec_halt = 1'b0;
    chk_eq("resume_state", 32'(state), 32'd1);
    chk_eq("resume_halted", 32'(halted), 32'd0);
    chk_eq("resume_retired", 32'(retired), 32'd7);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'd8);

    // Fetch timeout: no ack for 4 cycles leads to a sticky ERR.
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_eq("to_fetch_state", 32'(state), 32'd1);
      step();
    end
    chk_eq("to_err_state", 32'(state), 32'd7);
    chk_eq("to_err_flag", 32'(err), 32'd1);
    chk_eq("to_err_req", 32'(imem_req), 32'd0);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    chk_eq("err_sticky", 32'(state), 32'd7);
    chk_eq("err_sticky_flag", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("err_reset_state", 32'(state), 32'd0);
    chk_eq("err_reset_flag", 32'(err), 32'd0);
    chk_eq("err_reset_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;

    // Reset during a data-memory wait drops the request immediately.
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    dec_reg_write = 1'b0; dec_mem_write = 1'b1; dec_sel_wb = 1'b0;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    step();
    chk_eq("mr_mem_state", 32'(state), 32'd4);
    chk_eq("mr_mem_req", 32'(dmem_req), 32'd1);
    step();
    chk_eq("mr_mem_wait", 32'(state), 32'd4);
    #3;
    rst_n = 1'b0;
    #1;
    chk_eq("mr_req_drop", 32'(dmem_req), 32'd0);
    chk_eq("mr_state", 32'(state), 32'd0);
    chk_eq("mr_retired", 32'(retired), 32'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    step();
    step();
    dmem_ack = 1'b0;
    chk_eq("stray_ack_state", 32'(state), 32'd0);
    chk_eq("stray_ack_retired", 32'(retired), 32'd0);
    chk_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
